// File: rtl/afifo_wr_arbiter_pkg.sv
// Shared types and helpers for the packet-level write-port arbiter of an async FIFO.
package afifo_arb_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      XFER = 1'b1
   } arb_state_e;

   localparam int RR_W = 32;

   // Behavioural round-robin pick: first request after 'last', wrapping within n channels.
   function automatic logic [RR_W-1:0] rr_pick(input logic [RR_W-1:0] req,
                                               input int unsigned      last,
                                               input int unsigned      n);
      logic [RR_W-1:0] pick;
      logic [4:0]      idx;
      logic            found;
      pick  = {RR_W{1'b0}};
      found = 1'b0;
      for (int unsigned k = 1; k <= RR_W; k++) begin
         if (k <= n) begin
            idx = 5'((last + k) % n);
            if (!found && req[idx]) begin
               pick[idx] = 1'b1;
               found     = 1'b1;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/afifo_wr_arbiter_if.sv
// Requester stream bundle plus the write side of the shared async FIFO.
interface afifo_wr_arbiter_if #(
   parameter int N     = 4,
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
);
   localparam int CHW = $clog2(N);
   localparam int UW  = $clog2(DEPTH + 1);

   logic [N-1:0]       ch_enable;
   logic [N-1:0]       ch_valid;
   logic [N*WIDTH-1:0] ch_data;
   logic [N-1:0]       ch_last;
   logic [N-1:0]       ch_ready;
   logic               fifo_wr_req;
   logic [WIDTH+CHW:0] fifo_wr_data;
   logic               fifo_wr_full;
   logic [UW-1:0]      fifo_wr_used;

   modport master (
      input  ch_enable, ch_valid, ch_data, ch_last, fifo_wr_full, fifo_wr_used,
      output ch_ready, fifo_wr_req, fifo_wr_data
   );

   modport slave (
      output ch_enable, ch_valid, ch_data, ch_last, fifo_wr_full, fifo_wr_used,
      input  ch_ready, fifo_wr_req, fifo_wr_data
   );
endinterface

// File: rtl/afifo_wr_arbiter_rr_pick.sv
// Round-robin pick: rotate so the channel after 'last' lands at bit 0, take the
// lowest set bit, rotate back. Purely combinational; reusable by other arbiters.
module rr_priority_pick #(
   parameter  int N   = 4,
   localparam int CHW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [CHW-1:0] last,
   output logic [N-1:0]   pick
);
   localparam logic [CHW-1:0] LAST_CH = CHW'(N - 1);
   localparam logic [CHW-1:0] ONE_CH  = CHW'(1'b1);
   localparam logic [N-1:0]   ONE_N   = {{(N-1){1'b0}}, 1'b1};

   logic [CHW-1:0] start_s;
   logic [2*N-1:0] dbl_s;
   logic [2*N-1:0] unrot_s;
   logic [N-1:0]   rot_s;
   logic [N-1:0]   low_s;

   // Rotate, isolate lowest request, unrotate.
   always_comb begin
      if (last == LAST_CH) begin
         start_s = {CHW{1'b0}};
      end else begin
         start_s = last + ONE_CH;
      end
      dbl_s   = {req, req} >> start_s;
      rot_s   = dbl_s[N-1:0];
      low_s   = rot_s & (~rot_s + ONE_N);
      unrot_s = {low_s, low_s} << start_s;
      pick    = unrot_s[2*N-1:N];
   end
endmodule

// File: rtl/afifo_wr_arbiter.sv
// Packet-level round-robin arbiter sharing one async FIFO write port among N streams;
// every written word is tagged {last, channel, data} for demultiplexing on the read side.
module afifo_wr_arbiter
   import afifo_arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 8,
   parameter int MINSPACE = 1,
   parameter int MAXLEN   = 16
) (
   input  logic               wr_clk,
   input  logic               wr_rst,
   afifo_wr_arbiter_if.master bus,
   output logic [N-1:0]       grant,
   output logic               busy,
   output logic               trunc
);
   localparam int CHW = $clog2(N);
   localparam int UW  = $clog2(DEPTH + 1);
   localparam int SPW = UW + 2;
   localparam int BW  = $clog2(MAXLEN + 1);
   localparam logic [BW-1:0]  LAST_BEAT = BW'(MAXLEN - 1);
   localparam logic [BW-1:0]  BEAT_ONE  = BW'(1'b1);
   localparam logic [CHW-1:0] LAST_CH   = CHW'(N - 1);

   if (N < 2) begin : g_bad_n
      $error("afifo_wr_arbiter: N must be at least 2");
   end
   if (MINSPACE < 1 || MINSPACE > DEPTH) begin : g_bad_minspace
      $error("afifo_wr_arbiter: MINSPACE must be within 1..DEPTH");
   end
   if (MAXLEN < 1) begin : g_bad_maxlen
      $error("afifo_wr_arbiter: MAXLEN must be at least 1");
   end

   arb_state_e     state_q, state_d;
   logic [N-1:0]   grant_q, grant_d;
   logic [CHW-1:0] rr_last_q, rr_last_d;
   logic [BW-1:0]  beat_q, beat_d;
   logic           trunc_q, trunc_d;

   logic [N-1:0]     cand_s;
   logic [N-1:0]     pick_s;
   logic             space_ok_s;
   logic [CHW-1:0]   gidx_s;
   logic [WIDTH-1:0] word_s;
   logic             valid_g_s;
   logic             last_g_s;
   logic             eop_s;
   logic             accept_s;

   assign cand_s     = bus.ch_valid & bus.ch_enable;
   assign space_ok_s = (SPW'(bus.fifo_wr_used) + SPW'(MINSPACE)) <= SPW'(DEPTH);

   rr_priority_pick #(.N(N)) u_pick (
      .req  (cand_s),
      .last (rr_last_q),
      .pick (pick_s)
   );

   // One-hot grant selects the channel index, word and last flag by OR-reduction.
   always_comb begin
      gidx_s = {CHW{1'b0}};
      word_s = {WIDTH{1'b0}};
      for (int i = 0; i < N; i++) begin
         gidx_s = gidx_s | (grant_q[i] ? CHW'(i) : {CHW{1'b0}});
         word_s = word_s | (bus.ch_data[i*WIDTH +: WIDTH] & {WIDTH{grant_q[i]}});
      end
      valid_g_s = |(bus.ch_valid & grant_q);
      last_g_s  = |(bus.ch_last & grant_q);
      eop_s     = last_g_s | (beat_q == LAST_BEAT);
      accept_s  = (state_q == XFER) & valid_g_s & ~bus.fifo_wr_full;
   end

   // Next-state and port outputs; a cut packet (eop without ch_last) raises trunc next cycle.
   always_comb begin
      state_d          = state_q;
      grant_d          = grant_q;
      rr_last_d        = rr_last_q;
      beat_d           = beat_q;
      trunc_d          = 1'b0;
      bus.ch_ready     = {N{1'b0}};
      bus.fifo_wr_req  = 1'b0;
      bus.fifo_wr_data = {eop_s, gidx_s, word_s};
      case (state_q)
         IDLE: begin
            if ((cand_s != {N{1'b0}}) && space_ok_s) begin
               grant_d = pick_s;
               state_d = XFER;
            end else begin
               state_d = IDLE;
            end
         end
         XFER: begin
            bus.ch_ready    = grant_q & {N{~bus.fifo_wr_full}};
            bus.fifo_wr_req = accept_s;
            if (accept_s && eop_s) begin
               rr_last_d = gidx_s;
               grant_d   = {N{1'b0}};
               beat_d    = {BW{1'b0}};
               trunc_d   = ~last_g_s;
               state_d   = IDLE;
            end else if (accept_s) begin
               beat_d = beat_q + BEAT_ONE;
            end else begin
               state_d = XFER;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = {N{1'b0}};
         end
      endcase
   end

   // State registers with asynchronous reset.
   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         state_q   <= IDLE;
         grant_q   <= {N{1'b0}};
         rr_last_q <= LAST_CH;
         beat_q    <= {BW{1'b0}};
         trunc_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_last_q <= rr_last_d;
         beat_q    <= beat_d;
         trunc_q   <= trunc_d;
      end
   end

   assign grant = grant_q;
   assign busy  = (state_q == XFER);
   assign trunc = trunc_q;
endmodule
